drift_table_gen: RTL and testbench
==================================

Name: drift_table_gen

Overview:
- Parametrised successor to the single-asset drift sequencer.
- Takes one start pulse and, for each of NCH assets, sweeps t over a runtime range [iTMin, iTMax].
- For each (channel, t) it issues t*mu to the external exp/scale datapath, which computes S0*exp(t*mu).
- It realigns the returned product with its address tag and writes the result into the drift table RAM.
- It replaces fixed-delay timing with a valid-tagged delay line, and adds abort, range-error and busy/done handshakes.

Parameters:
NCH, 2, number of asset channels swept sequentially (>=1)
TW, 9, width of t / table index (unsigned integer)
MW, 18, width of mu and oTmu (all fraction bits)
SW, 18, width of S0 (passed through unchanged)
DW, 18, width of datapath result / oData
DP_LAT, 4, fixed external datapath latency, oReqValid cycle to iProd valid cycle (>=1)
CW, max(1,clog2(NCH)), channel index width (derived)

Ports:
CLK  in  1  clock, all logic on rising edge
nRST  in  1  asynchronous active-low reset
iStart  in  1  start pulse; sampled only in IDLE
iAbort  in  1  synchronous abort; wins over all other inputs
iTMin  in  TW  first t, latched at start
iTMax  in  TW  last t inclusive, latched at start
iMu  in  NCH*MW  per-channel mu, channel c at [c*MW +: MW], latched at start
iS  in  NCH*SW  per-channel S0, latched at start
oTmu  out  MW  t*mu to datapath
oS  out  SW  S0 of the channel being issued, aligned with oTmu
oReqValid  out  1  oTmu/oS valid
iProd  in  DW  datapath result; meaningful exactly DP_LAT cycles after the matching oReqValid
oData  out  DW  registered result
oAddr  out  CW+TW  {channel, t}
oWe  out  1  write strobe for oData/oAddr
oBusy  out  1  high in RUN and DRAIN
oDone  out  1  one-cycle completion pulse
oErr  out  1  one-cycle pulse on empty range (iTMin > iTMax)

Behaviour:
- Reset: all outputs 0, state IDLE, all delay-line valid bits 0. Reset asserted mid-sweep kills the sweep; no oDone or oErr is produced afterwards.
- States and transitions:
  - IDLE: on iStart, latch iTMin, iTMax, iMu and iS.
    - If iTMin > iTMax: pulse oErr next cycle, stay IDLE.
    - Otherwise go to RUN with ch=0, t=iTMin.
  - RUN: one issue per cycle, no stalls.
    - Increment t; on t==tmax wrap t to tmin and increment ch.
    - After issuing (NCH-1, tmax), go to DRAIN.
  - DRAIN: wait until the delay line is empty, then go to IDLE and pulse oDone.
- Issue stage (registered, 1 cycle):
  - oTmu = min(t*mu, 2^MW-1). The product of TW-bit unsigned t and the MW-fraction-bit mu keeps MW fraction bits and saturates just below 1.0.
  - oS = S0[ch]; oReqValid = 1.
  - Tag {ch,t} enters a DP_LAT-deep valid-tagged shift register in the same cycle.
- Writeback: in the cycle the tag exits with valid=1, register oData <= iProd, oAddr <= tag and oWe <= 1 on the next edge.
- Latency: issue cycle k gives oReqValid at k+1, iProd sampled at k+1+DP_LAT, oWe at k+2+DP_LAT.
- Ordering: writes occur in issue order, channel-major then t ascending.
- Total writes per sweep = NCH*(tmax-tmin+1). oDone is asserted the cycle after the final oWe.
- iStart while oBusy=1 is ignored, with no relatch.
- iAbort in any state, effective next edge:
  - Clear oReqValid and all delay-line valids; oWe is 0 from the next cycle on.
  - Go to IDLE with no oDone.
  - iAbort together with iStart in IDLE means abort wins and no sweep starts.
- iTMin==iTMax is legal: one issue per channel.
- iTMax = 2^TW-1 must not wrap the t counter. Compare before incrementing.
- Changes to iMu, iS, iTMin or iTMax during a sweep have no effect.

Test Plan:
1. NCH=2, DP_LAT=4, tmin=0, tmax=3, mu0=0x00400, mu1=0x00800, model datapath iProd = oTmu delayed 4 cycles; iStart at cycle 0 gives:
   - oTmu sequence 0x0, 0x400, 0x800, 0xC00, 0x0, 0x800, 0x1000, 0x1800;
   - oWe in cycles 7..14 with oAddr {0,0}..{0,3},{1,0}..{1,3} and matching oData;
   - oDone at cycle 15; oBusy high for cycles 1..14.
2. tmin=5, tmax=3 -> oErr one pulse, no oReqValid, no oWe, oBusy stays 0.
3. tmin=tmax=511, TW=9, mu=0x3FFFF -> oTmu saturates to 0x3FFFF; exactly NCH writes at t=511; no counter wrap.
4. iAbort asserted during the third write -> no further oWe, no oDone, oBusy=0 next cycle; a new iStart then runs a full correct sweep.
5. nRST pulsed low mid-DRAIN -> all outputs 0 immediately; no spurious oWe/oDone after release.
6. iStart re-pulsed and iMu changed during RUN -> ignored; results still match the originally latched mu; single oDone.

Source files
------------

// File: rtl/drift_table_gen.sv
// rtl/drift_table_gen.sv - multi-channel drift table sequencer with tagged datapath realignment
module drift_table_gen #(
  parameter int NCH    = 2,
  parameter int TW     = 9,
  parameter int MW     = 18,
  parameter int SW     = 18,
  parameter int DW     = 18,
  parameter int DP_LAT = 4,
  parameter int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [TW-1:0]       iTMin,
  input  logic [TW-1:0]       iTMax,
  input  logic [NCH*MW-1:0]   iMu,
  input  logic [NCH*SW-1:0]   iS,
  output logic [MW-1:0]       oTmu,
  output logic [SW-1:0]       oS,
  output logic                oReqValid,
  input  logic [DW-1:0]       iProd,
  output logic [DW-1:0]       oData,
  output logic [CW+TW-1:0]    oAddr,
  output logic                oWe,
  output logic                oBusy,
  output logic                oDone,
  output logic                oErr
);

  localparam int AW = CW + TW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Sweep parameters captured at start; later input changes are invisible.
  logic [TW-1:0]     tmin_q, tmin_d;
  logic [TW-1:0]     tmax_q, tmax_d;
  logic [NCH*MW-1:0] mu_q, mu_d;
  logic [NCH*SW-1:0] s_q, s_d;

  // Sweep position of the next issue.
  logic [TW-1:0]     t_q, t_d;
  logic [CW-1:0]     ch_q, ch_d;

  // Issue stage registers (drive the external datapath).
  logic [MW-1:0]     tmu_q, tmu_d;
  logic [SW-1:0]     s_out_q, s_out_d;
  logic              req_vld_q, req_vld_d;
  logic [AW-1:0]     req_tag_q, req_tag_d;

  // Valid-tagged delay line that realigns {ch,t} with the returning product.
  logic [DP_LAT-1:0] dl_vld_q, dl_vld_d;
  logic [AW-1:0]     dl_tag_q [DP_LAT];
  logic [AW-1:0]     dl_tag_d [DP_LAT];

  // Writeback and status registers.
  logic [DW-1:0]     data_q, data_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Decoded control terms.
  logic              start_ok;
  logic              range_bad;
  logic              issue;
  logic              last_t;
  logic              last_ch;
  logic              line_empty;
  logic [MW-1:0]     mu_sel;
  logic [SW-1:0]     s_sel;
  logic [TW+MW-1:0]  prod_full;
  logic [MW-1:0]     tmu_sat;

  assign start_ok   = (state_q == ST_IDLE) && iStart && !iAbort;
  assign range_bad  = iTMin > iTMax;
  assign issue      = (state_q == ST_RUN) && !iAbort;
  // t is compared against tmax before any increment so tmax = all-ones never wraps.
  assign last_t     = (t_q == tmax_q);
  assign last_ch    = (ch_q == CW'(NCH - 1));
  // Empty means nothing in flight between the issue register and the last tap.
  assign line_empty = !req_vld_q && (dl_vld_q == '0);

  // Per-channel operand select from the latched mu / S0 vectors.
  always_comb begin
    mu_sel = '0;
    s_sel  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_q == CW'(c)) begin
        mu_sel = mu_q[c*MW +: MW];
        s_sel  = s_q[c*SW +: SW];
      end
    end
  end

  // t*mu keeps mu's MW fraction bits; any integer part saturates just below 1.0.
  always_comb begin
    prod_full = {{MW{1'b0}}, t_q} * {{TW{1'b0}}, mu_sel};
    tmu_sat   = (prod_full[TW+MW-1:MW] != '0) ? {MW{1'b1}} : prod_full[MW-1:0];
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides every other input.
  always_comb begin
    state_d = state_q;
    if (iAbort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (iStart && !range_bad) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (last_t && last_ch) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (line_empty) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: latch, issue, delay line shift, writeback and status pulses.
  always_comb begin
    tmin_d    = tmin_q;
    tmax_d    = tmax_q;
    mu_d      = mu_q;
    s_d       = s_q;
    t_d       = t_q;
    ch_d      = ch_q;
    tmu_d     = tmu_q;
    s_out_d   = s_out_q;
    req_vld_d = 1'b0;
    req_tag_d = req_tag_q;
    data_d    = data_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    dl_vld_d[0] = req_vld_q;
    dl_tag_d[0] = req_tag_q;
    for (int i = 1; i < DP_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end

    if (start_ok) begin
      tmin_d = iTMin;
      tmax_d = iTMax;
      mu_d   = iMu;
      s_d    = iS;
      t_d    = iTMin;
      ch_d   = '0;
      err_d  = range_bad;
    end

    if (issue) begin
      tmu_d     = tmu_sat;
      s_out_d   = s_sel;
      req_vld_d = 1'b1;
      req_tag_d = {ch_q, t_q};
      if (last_t) begin
        t_d = tmin_q;
        if (!last_ch) ch_d = ch_q + CW'(1);
      end else begin
        t_d = t_q + TW'(1);
      end
    end

    // The tag leaving the last tap lines up with iProd in this cycle.
    if (dl_vld_q[DP_LAT-1]) begin
      data_d = iProd;
      addr_d = dl_tag_q[DP_LAT-1];
      we_d   = 1'b1;
    end

    if ((state_q == ST_DRAIN) && line_empty) done_d = 1'b1;

    if (iAbort) begin
      req_vld_d = 1'b0;
      dl_vld_d  = '0;
      we_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmin_q    <= '0;
      tmax_q    <= '0;
      mu_q      <= '0;
      s_q       <= '0;
      t_q       <= '0;
      ch_q      <= '0;
      tmu_q     <= '0;
      s_out_q   <= '0;
      req_vld_q <= 1'b0;
      req_tag_q <= '0;
      dl_vld_q  <= '0;
      for (int i = 0; i < DP_LAT; i++) dl_tag_q[i] <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tmin_q    <= tmin_d;
      tmax_q    <= tmax_d;
      mu_q      <= mu_d;
      s_q       <= s_d;
      t_q       <= t_d;
      ch_q      <= ch_d;
      tmu_q     <= tmu_d;
      s_out_q   <= s_out_d;
      req_vld_q <= req_vld_d;
      req_tag_q <= req_tag_d;
      dl_vld_q  <= dl_vld_d;
      dl_tag_q  <= dl_tag_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign oTmu      = tmu_q;
  assign oS        = s_out_q;
  assign oReqValid = req_vld_q;
  assign oData     = data_q;
  assign oAddr     = addr_q;
  assign oWe       = we_q;
  assign oBusy     = (state_q != ST_IDLE);
  assign oDone     = done_q;
  assign oErr      = err_q;

endmodule

// File: tb/tb_drift_table_gen.sv
// tb/tb_drift_table_gen.sv - scoreboard bench for drift_table_gen
module tb_drift_table_gen;

  localparam int NCH    = 2;
  localparam int TW     = 9;
  localparam int MW     = 18;
  localparam int SW     = 18;
  localparam int DW     = 18;
  localparam int DP_LAT = 4;
  localparam int CW     = 1;
  localparam int AW     = CW + TW;

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic              iStart = 1'b0;
  logic              iAbort = 1'b0;
  logic [TW-1:0]     iTMin = '0;
  logic [TW-1:0]     iTMax = '0;
  logic [NCH*MW-1:0] iMu = '0;
  logic [NCH*SW-1:0] iS = '0;
  logic [MW-1:0]     oTmu;
  logic [SW-1:0]     oS;
  logic              oReqValid;
  logic [DW-1:0]     iProd = '0;
  logic [DW-1:0]     oData;
  logic [AW-1:0]     oAddr;
  logic              oWe;
  logic              oBusy;
  logic              oDone;
  logic              oErr;

  drift_table_gen #(
    .NCH(NCH), .TW(TW), .MW(MW), .SW(SW), .DW(DW), .DP_LAT(DP_LAT), .CW(CW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .iStart(iStart), .iAbort(iAbort),
    .iTMin(iTMin), .iTMax(iTMax), .iMu(iMu), .iS(iS),
    .oTmu(oTmu), .oS(oS), .oReqValid(oReqValid), .iProd(iProd),
    .oData(oData), .oAddr(oAddr), .oWe(oWe), .oBusy(oBusy),
    .oDone(oDone), .oErr(oErr)
  );

  typedef struct {
    logic [MW-1:0] tmu;
    logic [SW-1:0] s;
    int            cyc;
  } req_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  req_t req_q[$];
  wr_t  wr_q[$];
  int   done_q[$];
  int   err_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  bit busy_chk = 1'b0;

  logic [MW-1:0] exp_a [8];
  logic [DW-1:0] ring [8];

  initial forever #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External datapath model: iProd is oTmu from DP_LAT cycles earlier, garbage otherwise.
  initial begin
    for (int i = 0; i < 8; i++) ring[i] = 18'h2AAAA;
    forever begin
      @(negedge CLK);
      ring[cyc % 8] = oReqValid ? oTmu : 18'h2AAAA;
      iProd = ring[(cyc + 8 - DP_LAT) % 8];
    end
  end

  // Monitor: pops expected events whenever the DUT presents them.
  initial begin
    req_t r;
    wr_t  w;
    int   d;
    forever begin
      @(negedge CLK);
      if (oReqValid) begin
        if (req_q.size() == 0) chk("req_unexpected", 64'(oReqValid), 64'd0);
        else begin
          r = req_q.pop_front();
          chk("req_tmu", 64'(oTmu), 64'(r.tmu));
          chk("req_s", 64'(oS), 64'(r.s));
          chk("req_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
      if (oWe) begin
        if (wr_q.size() == 0) chk("we_unexpected", 64'(oWe), 64'd0);
        else begin
          w = wr_q.pop_front();
          chk("we_addr", 64'(oAddr), 64'(w.addr));
          chk("we_data", 64'(oData), 64'(w.data));
          chk("we_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (oDone) begin
        if (done_q.size() == 0) chk("done_unexpected", 64'(oDone), 64'd0);
        else begin
          d = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d));
        end
      end
      if (oErr) begin
        if (err_q.size() == 0) chk("err_unexpected", 64'(oErr), 64'd0);
        else begin
          d = err_q.pop_front();
          chk("err_cycle", 64'(cyc), 64'(d));
        end
      end
      if (busy_chk) chk("busy", 64'(oBusy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
    end
  end

  task automatic apply(input int tmin, input int tmax, input logic [MW-1:0] mu0,
                       input logic [MW-1:0] mu1, input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    @(negedge CLK);
    iTMin     = TW'(tmin);
    iTMax     = TW'(tmax);
    iMu       = {mu1, mu0};
    iS        = {s1, s0};
    iStart    = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic drop_start();
    @(negedge CLK);
    iStart = 1'b0;
  endtask

  // Queue expected issues/writes for n issues of nt t-values per channel.
  task automatic expect_sweep(input int n, input int nt, input int tmin, input logic [SW-1:0] s0,
                              input logic [SW-1:0] s1, input int nwr, input bit done);
    for (int i = 0; i < n; i++) begin
      req_t r;
      wr_t  w;
      int   ch;
      int   t;
      ch    = i / nt;
      t     = tmin + (i % nt);
      r.tmu = exp_a[i];
      r.s   = (ch == 0) ? s0 : s1;
      r.cyc = start_cyc + i + 2;
      req_q.push_back(r);
      if (i < nwr) begin
        w.addr = {CW'(ch), TW'(t)};
        w.data = exp_a[i];
        w.cyc  = start_cyc + i + 7;
        wr_q.push_back(w);
      end
    end
    if (done) done_q.push_back(start_cyc + n + 7);
    busy_lo = start_cyc + 1;
    busy_hi = start_cyc + n + 6;
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_req_left"}, 64'(req_q.size()), 64'd0);
    chk({tag, "_we_left"}, 64'(wr_q.size()), 64'd0);
    chk({tag, "_done_left"}, 64'(done_q.size()), 64'd0);
    chk({tag, "_err_left"}, 64'(err_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_oReqValid"}, 64'(oReqValid), 64'd0);
    chk({tag, "_oWe"}, 64'(oWe), 64'd0);
    chk({tag, "_oBusy"}, 64'(oBusy), 64'd0);
    chk({tag, "_oDone"}, 64'(oDone), 64'd0);
    chk({tag, "_oErr"}, 64'(oErr), 64'd0);
    chk({tag, "_oTmu"}, 64'(oTmu), 64'd0);
    chk({tag, "_oS"}, 64'(oS), 64'd0);
    chk({tag, "_oData"}, 64'(oData), 64'd0);
    chk({tag, "_oAddr"}, 64'(oAddr), 64'd0);
  endtask

  initial begin
    #2 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check_outputs_zero("reset");
    busy_chk = 1'b1;

    // Basic two-channel sweep t=0..3.
    exp_a = '{18'h0, 18'h400, 18'h800, 18'hC00, 18'h0, 18'h800, 18'h1000, 18'h1800};
    apply(0, 3, 18'h00400, 18'h00800, 18'h11111, 18'h22222);
    expect_sweep(8, 4, 0, 18'h11111, 18'h22222, 8, 1'b1);
    drop_start();
    repeat (20) @(negedge CLK);
    check_drained("sweep");

    // Empty range reports an error and never goes busy.
    apply(5, 3, 18'h00400, 18'h00800, 18'h11111, 18'h22222);
    err_q.push_back(start_cyc + 1);
    busy_lo = 1;
    busy_hi = 0;
    drop_start();
    repeat (10) @(negedge CLK);
    check_drained("range");

    // Single t at the top of the range; channel 0 saturates.
    exp_a = '{18'h3FFFF, 18'h3FE00, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
    apply(511, 511, 18'h3FFFF, 18'h00200, 18'h00AAA, 18'h00BBB);
    expect_sweep(2, 1, 511, 18'h00AAA, 18'h00BBB, 2, 1'b1);
    drop_start();
    repeat (20) @(negedge CLK);
    check_drained("tmax");

    // Abort together with start in IDLE: nothing starts.
    @(negedge CLK);
    iTMin  = 0;
    iTMax  = 3;
    iStart = 1'b1;
    iAbort = 1'b1;
    busy_lo = 1;
    busy_hi = 0;
    @(negedge CLK);
    iStart = 1'b0;
    iAbort = 1'b0;
    repeat (10) @(negedge CLK);
    check_drained("abort_start");

    // Abort during the third write, then a fresh full sweep.
    exp_a = '{18'h0, 18'h400, 18'h800, 18'hC00, 18'h0, 18'h800, 18'h1000, 18'h1800};
    apply(0, 3, 18'h00400, 18'h00800, 18'h11111, 18'h22222);
    expect_sweep(8, 4, 0, 18'h11111, 18'h22222, 3, 1'b0);
    busy_hi = start_cyc + 9;
    drop_start();
    repeat (8) @(negedge CLK);
    iAbort = 1'b1;
    @(negedge CLK);
    iAbort = 1'b0;
    repeat (15) @(negedge CLK);
    check_drained("abort");

    exp_a = '{18'h0, 18'h123, 18'h246, 18'h369, 18'h0, 18'h1000, 18'h2000, 18'h3000};
    apply(0, 3, 18'h00123, 18'h01000, 18'h00005, 18'h00006);
    expect_sweep(8, 4, 0, 18'h00005, 18'h00006, 8, 1'b1);
    drop_start();
    repeat (20) @(negedge CLK);
    check_drained("after_abort");

    // Reset pulse mid-drain kills the sweep.
    exp_a = '{18'h0, 18'h400, 18'h800, 18'hC00, 18'h0, 18'h800, 18'h1000, 18'h1800};
    busy_chk = 1'b0;
    apply(0, 3, 18'h00400, 18'h00800, 18'h11111, 18'h22222);
    expect_sweep(8, 4, 0, 18'h11111, 18'h22222, 5, 1'b0);
    drop_start();
    repeat (10) @(negedge CLK);
    #2 nRST = 1'b0;
    #1 check_outputs_zero("mid_reset");
    @(negedge CLK);
    nRST = 1'b1;
    busy_lo = 1;
    busy_hi = 0;
    busy_chk = 1'b1;
    repeat (20) @(negedge CLK);
    check_drained("reset_drain");

    // Restart and input changes during RUN are ignored.
    exp_a = '{18'h0, 18'h400, 18'h800, 18'hC00, 18'h0, 18'h800, 18'h1000, 18'h1800};
    apply(0, 3, 18'h00400, 18'h00800, 18'h11111, 18'h22222);
    expect_sweep(8, 4, 0, 18'h11111, 18'h22222, 8, 1'b1);
    drop_start();
    @(negedge CLK);
    @(negedge CLK);
    iStart = 1'b1;
    iMu    = {18'h3FFFF, 18'h00001};
    iS     = {18'h00000, 18'h3FFFF};
    iTMin  = 1;
    iTMax  = 2;
    @(negedge CLK);
    iStart = 1'b0;
    repeat (20) @(negedge CLK);
    check_drained("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
